// File: rtl/llsc_monitor.sv
// llsc_monitor: per-channel load-linked/store-conditional reservation tracker.
module llsc_monitor #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          flush,
    input  logic [NUM_CH-1:0]          ll_we,
    input  logic [NUM_CH*ADDR_W-1:0]   ll_addr,
    input  logic [NUM_CH-1:0]          sc_req,
    input  logic [NUM_CH*ADDR_W-1:0]   sc_addr,
    input  logic [NUM_CH-1:0]          st_we,
    input  logic [NUM_CH*ADDR_W-1:0]   st_addr,
    input  logic                       ext_inv,
    input  logic [ADDR_W-1:0]          ext_inv_addr,
    output logic [NUM_CH-1:0]          sc_ok,
    output logic [NUM_CH-1:0]          LLbit_o
);
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [NUM_CH-1:0] valid, raw, win, kill;
    logic [ADDR_W-1:0] resv [NUM_CH];
    logic [CW-1:0]     cnt  [NUM_CH];

    // Granule compare: differences below GRAN_LSB are shifted out.
    function automatic logic match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) >> GRAN_LSB) == '0;
    endfunction

    always_comb begin
        raw  = '0;
        win  = '0;
        kill = '0;
        for (int i = 0; i < NUM_CH; i++)
            raw[i] = !rst && sc_req[i] && valid[i] && !flush[i] && match(sc_addr[i*ADDR_W +: ADDR_W], resv[i]);
        for (int i = 0; i < NUM_CH; i++) begin
            win[i] = raw[i];
            for (int j = 0; j < i; j++)
                if (raw[j] && match(sc_addr[j*ADDR_W +: ADDR_W], sc_addr[i*ADDR_W +: ADDR_W])) win[i] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            kill[i] = valid[i] && ext_inv && match(ext_inv_addr, resv[i]);
            for (int j = 0; j < NUM_CH; j++)
                if (valid[i] && j != i &&
                    ((st_we[j] && match(st_addr[j*ADDR_W +: ADDR_W], resv[i])) ||
                     (win[j] && match(sc_addr[j*ADDR_W +: ADDR_W], resv[i]))))
                    kill[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                resv[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (flush[i]) begin
                    valid[i] <= 1'b0;
                end else if (ll_we[i]) begin
                    valid[i] <= 1'b1;
                    resv[i]  <= ll_addr[i*ADDR_W +: ADDR_W];
                    cnt[i]   <= CW'(TIMEOUT);
                end else if (sc_req[i] || kill[i]) begin
                    valid[i] <= 1'b0;
                end else if (TIMEOUT != 0 && valid[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                    if (cnt[i] == CW'(1)) valid[i] <= 1'b0;
                end
            end
        end
    end

    assign sc_ok   = win;
    assign LLbit_o = valid;
endmodule

// File: tb/tb_llsc_monitor.sv
// tb_llsc_monitor: directed scenarios plus random traffic against a rule-level reservation model.
module tb_llsc_monitor;
    localparam int N = 2;
    localparam int T = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  flush, ll_we, sc_req, st_we, sc_ok, LLbit_o;
    logic [N*32-1:0] ll_addr, sc_addr, st_addr;
    logic          ext_inv;
    logic [31:0]   ext_inv_addr;
    logic [31:0]   lla [N];
    logic [31:0]   sca [N];
    logic [31:0]   sta [N];

    logic [N-1:0]  mv;
    logic [31:0]   ma [N];
    int            ml [N];
    int            checks = 0;
    int            errors = 0;

    assign ll_addr = {lla[1], lla[0]};
    assign sc_addr = {sca[1], sca[0]};
    assign st_addr = {sta[1], sta[0]};

    always #5 clk = ~clk;

    llsc_monitor #(.NUM_CH(N), .ADDR_W(32), .GRAN_LSB(2), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ll_we(ll_we), .ll_addr(ll_addr),
        .sc_req(sc_req), .sc_addr(sc_addr), .st_we(st_we), .st_addr(st_addr),
        .ext_inv(ext_inv), .ext_inv_addr(ext_inv_addr), .sc_ok(sc_ok), .LLbit_o(LLbit_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic same(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    task automatic idle();
        flush = '0; ll_we = '0; sc_req = '0; st_we = '0; ext_inv = 1'b0; ext_inv_addr = '0;
        for (int i = 0; i < N; i++) begin
            lla[i] = '0; sca[i] = '0; sta[i] = '0;
        end
    endtask

    task automatic step(input string tag);
        logic [N-1:0] r, ok, k;
        #1;
        r = '0; ok = '0; k = '0;
        for (int i = 0; i < N; i++)
            r[i] = !rst && sc_req[i] && mv[i] && !flush[i] && same(sca[i], ma[i]);
        for (int i = 0; i < N; i++) begin
            ok[i] = r[i];
            for (int j = 0; j < i; j++)
                if (r[j] && same(sca[j], sca[i])) ok[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            k[i] = mv[i] && ext_inv && same(ext_inv_addr, ma[i]);
            for (int j = 0; j < N; j++)
                if (j != i && mv[i] && ((st_we[j] && same(sta[j], ma[i])) || (ok[j] && same(sca[j], ma[i]))))
                    k[i] = 1'b1;
        end
        check({tag, "/sc_ok"}, 32'(sc_ok), 32'(ok));
        check({tag, "/llbit"}, 32'(LLbit_o), 32'(mv));
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                mv[i] = 1'b0; ma[i] = '0; ml[i] = 0;
            end else if (flush[i]) begin
                mv[i] = 1'b0;
            end else if (ll_we[i]) begin
                mv[i] = 1'b1; ma[i] = lla[i]; ml[i] = T;
            end else if (sc_req[i] || k[i]) begin
                mv[i] = 1'b0;
            end else if (mv[i] && T != 0) begin
                ml[i]--;
                if (ml[i] == 0) mv[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_ok(input string tag, input logic [N-1:0] v);
        #1;
        check(tag, 32'(sc_ok), 32'(v));
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h1000 + ($urandom_range(0, 2) << 2) + $urandom_range(0, 3);
    endfunction

    initial begin
        mv = '0;
        for (int i = 0; i < N; i++) begin
            ma[i] = '0; ml[i] = 0;
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        check("reset_llbit", 32'(LLbit_o), 32'h0);
        expect_ok("reset_scok", '0);
        step("reset");
        rst = 1'b0;
        step("idle");

        ll_we[0] = 1'b1; lla[0] = 32'h1000; step("r34_ll");
        idle(); step("r34_gap");
        sc_req[0] = 1'b1; sca[0] = 32'h1002; expect_ok("r34_sc", 2'b01); step("r34_sc");
        idle(); check("r34_clr", 32'(LLbit_o[0]), 32'h0);

        ll_we[0] = 1'b1; lla[0] = 32'h1000; step("r35_ll");
        idle(); st_we[1] = 1'b1; sta[1] = 32'h1001; step("r35_st1");
        idle(); sc_req[0] = 1'b1; sca[0] = 32'h1000; expect_ok("r35_killed", 2'b00); step("r35_sc");
        idle(); ll_we[0] = 1'b1; lla[0] = 32'h1000; step("r35_ll2");
        idle(); st_we[0] = 1'b1; sta[0] = 32'h1000; step("r35_st0");
        idle(); sc_req[0] = 1'b1; sca[0] = 32'h1000; expect_ok("r35_own", 2'b01); step("r35_sc2");

        idle(); ll_we = 2'b11; lla[0] = 32'h2000; lla[1] = 32'h2000; step("r36_ll");
        idle(); sc_req = 2'b11; sca[0] = 32'h2000; sca[1] = 32'h2000; expect_ok("r36_arb", 2'b01); step("r36_sc");
        idle(); check("r36_clr", 32'(LLbit_o), 32'h0);

        ll_we[0] = 1'b1; lla[0] = 32'h1000; step("r37_ll");
        idle();
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("r37_live%0d", c), 32'(LLbit_o[0]), 32'h1);
            step("r37_wait");
        end
        check("r37_expired", 32'(LLbit_o[0]), 32'h0);
        sc_req[0] = 1'b1; sca[0] = 32'h1000; expect_ok("r37_sc", 2'b00); step("r37_sc");

        idle(); ll_we[1] = 1'b1; flush[1] = 1'b1; lla[1] = 32'h3000; step("r38_flush");
        idle(); check("r38_flush", 32'(LLbit_o[1]), 32'h0);
        ll_we[0] = 1'b1; lla[0] = 32'h3000; ext_inv = 1'b1; ext_inv_addr = 32'h3000; step("r38_inv");
        idle(); check("r38_inv", 32'(LLbit_o[0]), 32'h1);

        rst = 1'b1; step("r39_rst");
        rst = 1'b0; check("r39_clr", 32'(LLbit_o), 32'h0);
        sc_req[0] = 1'b1; sca[0] = 32'h3000; expect_ok("r39_sc", 2'b00); step("r39_sc");

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                flush[i]  = ($urandom_range(0, 15) == 0);
                ll_we[i]  = ($urandom_range(0, 3) == 0);
                sc_req[i] = ($urandom_range(0, 3) == 0);
                st_we[i]  = ($urandom_range(0, 4) == 0);
                lla[i] = rnd_addr(); sca[i] = rnd_addr(); sta[i] = rnd_addr();
            end
            ext_inv = ($urandom_range(0, 7) == 0);
            ext_inv_addr = rnd_addr();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
